booth_seq_mul: RTL
==================

BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 SHALL provide parameter A_LEN, default 256, multiplicand width in bits.
REQ-002 SHALL provide parameter B_LEN, default 64, multiplier width in bits; it SHALL be even and at least 2.
REQ-003 SHALL provide parameter PROD_LEN, default A_LEN+B_LEN, product width; values below A_LEN+B_LEN truncate the product modulo 2^PROD_LEN.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  operands and mode are valid this cycle.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 A  input  A_LEN  multiplicand.
REQ-009 B  input  B_LEN  multiplier.
REQ-010 is_signed  input  1  1: A and B are two's complement; 0: both unsigned.
REQ-011 out_valid  output  1  prod holds a completed result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 prod  output  PROD_LEN  product A*B.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 An accept (in_valid && in_ready) SHALL register A, B and is_signed, clear the accumulator and digit counter, and move the FSM IDLE->CALC.
REQ-018 A SHALL be extended to PROD_LEN bits: sign-extended if is_signed, otherwise zero-extended.
REQ-019 B SHALL be extended to B_LEN+2 bits in the same way, giving N = B_LEN/2+1 radix-4 digits; bit b[-1] SHALL be 0.
REQ-020 Digit i SHALL be decoded from b[2i+1], b[2i], b[2i-1]: 000 and 111 give 0; 001 and 010 give +1; 011 gives +2; 100 gives -2; 101 and 110 give -1.
REQ-021 Each CALC cycle SHALL process exactly one digit: add (digit*A_ext) << 2i to the accumulator, with negation in two's complement, modulo 2^PROD_LEN.
REQ-022 After the cycle that processes digit N-1, the FSM SHALL move CALC->DONE.
REQ-023 Latency is fixed: operands accepted on edge t produce out_valid=1 from edge t+N onward; for the defaults this is N=33.
REQ-024 Latency SHALL NOT depend on the operand values, including zero operands.
REQ-025 In DONE, prod SHALL hold the final result stable until out_valid && out_ready; the FSM then moves DONE->IDLE.
REQ-026 prod SHALL read 0 whenever out_valid=0.
REQ-027 In_valid outside IDLE SHALL be ignored; no operands SHALL be captured, queued or lost-state created.
REQ-028 Operand inputs SHALL only be sampled on the accept edge; later changes SHALL NOT affect the result in progress.
REQ-029 The block SHALL hold one operation in flight; a new accept is possible only in IDLE, at the earliest one cycle after the DONE handshake.
REQ-030 The signed result SHALL be exact for the most-negative A and B, e.g. (-2^(A_LEN-1))*(-2^(B_LEN-1)) = 2^(A_LEN+B_LEN-2).
REQ-031 The unsigned result SHALL be exact for all-ones A and B.

Reset
REQ-032 While rst=1, the block SHALL be in IDLE with in_ready=1, out_valid=0, busy=0, prod=0, and the accumulator, counter and operand registers cleared; this applies immediately and asynchronously.
REQ-033 Reset asserted during CALC or DONE SHALL abandon the operation with no result emitted.
REQ-034 After rst deasserts, the first accept SHALL behave identically to one made after power-up.

Verification (A_LEN=8, B_LEN=4 unless stated; N=3)
REQ-035 Unsigned 255*15, is_signed=0 -> out_valid exactly 3 cycles after the accept edge, prod=0x0EF1.
REQ-036 Signed A=0x80 (-128), B=0x8 (-8), is_signed=1 -> prod=0x0400. Signed A=0x7F, B=0xF (-1) -> prod=0xFF81.
REQ-037 Hold out_ready=0 for 10 cycles in DONE while toggling A, B and in_valid -> prod stable, in_ready=0 throughout; release -> IDLE, in_ready=1 on the next cycle.
REQ-038 Assert rst during the second CALC cycle -> all outputs reset at once; the next operation 3*5 unsigned -> prod=0x000F with normal latency.
REQ-039 Defaults (256x64): 10k random signed and unsigned operand pairs with random out_ready stalls -> every prod matches a reference model, and each latency is 33.

Source files
------------

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, fixed latency of B_LEN/2+1 cycles.
// Single operation in flight with valid/ready handshakes on both the operand and result sides.
`timescale 1ns/1ps
module booth_seq_mul #(
    parameter int unsigned A_LEN    = 256,
    parameter int unsigned B_LEN    = 64,
    parameter int unsigned PROD_LEN = A_LEN + B_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [A_LEN-1:0]    A,
    input  logic [B_LEN-1:0]    B,
    input  logic                is_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_LEN-1:0] prod,
    output logic                busy
);

    localparam int unsigned N_DIG = B_LEN / 2 + 1;
    localparam int unsigned CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int unsigned BX_W  = B_LEN + 3;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [PROD_LEN-1:0] a_q, a_d;
    logic [PROD_LEN-1:0] acc_q, acc_d;
    logic [PROD_LEN-1:0] prod_q, prod_d;
    logic [PROD_LEN-1:0] addend;
    logic [BX_W-1:0]     b_q, b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // a_q is pre-shifted by 2i and b_q shifted down so the current digit always sits in b_q[2:0]
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        addend  = '0;

        case (b_q[2:0])
            3'b001, 3'b010: addend = a_q;
            3'b011:         addend = a_q << 1;
            3'b100:         addend = '0 - (a_q << 1);
            3'b101, 3'b110: addend = '0 - a_q;
            default:        addend = '0;
        endcase

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_signed) begin
                        a_d = PROD_LEN'($signed(A));
                        b_d = {(BX_W-1)'($signed(B)), 1'b0};
                    end else begin
                        a_d = PROD_LEN'(A);
                        b_d = {(BX_W-1)'(B), 1'b0};
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + addend;
                a_d   = a_q << 2;
                b_d   = b_q >> 2;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_DIG - 1)) begin
                    state_d = DONE;
                    prod_d  = acc_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    prod_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign prod      = prod_q;

endmodule
